// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI message parser:
//   - state_t        : parser state encoding
//   - status bytes   : named constants for the status values the parser
//                      treats specially
//   - status_data_len: number of data bytes that follow a status byte
// -----------------------------------------------------------------------------
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_t;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Data bytes expected after a status byte. 0 for statuses that carry no
  // data or are not message starts (F0, F4..FF, data bytes).
  function automatic logic [1:0] status_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
      len = 2'd1;
    end else if (status[7:4] >= 4'h8 && status[7:4] <= 4'hE) begin
      len = 2'd2;
    end else begin
      case (status)
        8'hF1, 8'hF3: len = 2'd1;
        8'hF2:        len = 2'd2;
        default:      len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// -----------------------------------------------------------------------------
// midi_status_decode
// Combinational classifier for one received byte.
// Ports:
//   status_byte   in  8  byte to classify
//   is_channel    out 1  80..EF (channel voice/mode message)
//   is_sys_common out 1  F1..F7
//   is_realtime   out 1  F8..FF
//   data_len      out 2  data bytes that follow this status
// -----------------------------------------------------------------------------
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0] status_byte,
  output logic       is_channel,
  output logic       is_sys_common,
  output logic       is_realtime,
  output logic [1:0] data_len
);

  assign is_channel    = status_byte[7] && (status_byte[7:4] != 4'hF);
  assign is_sys_common = (status_byte[7:3] == 5'b11110) && (status_byte[2:0] != 3'd0);
  assign is_realtime   = (status_byte >= RT_MIN);
  assign data_len      = status_data_len(status_byte);

endmodule

// File: rtl/midi_msg_parser.sv
// -----------------------------------------------------------------------------
// midi_msg_parser
// Assembles the receiver's byte stream into complete MIDI messages with
// running status, real-time pass-through, SysEx swallowing and an optional
// channel filter. Outputs are registered one cycle after the accepted byte.
// Ports:
//   sys_clk      in  1       system clock
//   rst          in  1       synchronous active-high reset
//   byte_in      in  BYTE_W  received byte
//   byte_is_cmd  in  1       byte_in[7] from the receiver (status byte)
//   byte_strobe  in  1       new-byte level; accepted on its rising edge
//   msg_valid    out 1       pulse: msg_status/data1/data2 hold a message
//   msg_status   out 8       message status byte
//   msg_data1    out 7       first data byte (0 if unused)
//   msg_data2    out 7       second data byte (0 if unused)
//   rt_valid     out 1       pulse: rt_byte holds a real-time byte
//   rt_byte      out 8       real-time byte F8..FF
//   sysex_active out 1       high while inside a SysEx block
//   err_strobe   out 1       pulse on a protocol error
// -----------------------------------------------------------------------------
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int         BYTE_W           = 8,
  parameter bit         OMNI             = 1'b1,
  parameter logic [3:0] CHANNEL          = 4'd0,
  parameter bit         NOTEON_V0_TO_OFF = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_is_cmd,
  input  logic              byte_strobe,
  output logic              msg_valid,
  output logic [7:0]        msg_status,
  output logic [6:0]        msg_data1,
  output logic [6:0]        msg_data2,
  output logic              rt_valid,
  output logic [7:0]        rt_byte,
  output logic              sysex_active,
  output logic              err_strobe
);

  logic [7:0] w_byte;
  logic       w_is_channel;
  logic       w_is_sys_common;
  logic       w_is_realtime;
  logic [1:0] w_len;

  assign w_byte = byte_in[7:0];

  midi_status_decode u_decode (
    .status_byte   (w_byte),
    .is_channel    (w_is_channel),
    .is_sys_common (w_is_sys_common),
    .is_realtime   (w_is_realtime),
    .data_len      (w_len)
  );

  // Parser state
  logic       r_strobe_q;
  state_t     r_state,   w_state_nxt;
  logic [7:0] r_status,  w_status_nxt;   // running status, 0 = none
  logic [6:0] r_data1,   w_data1_nxt;
  logic       r_partial, w_partial_nxt;  // status seen, no message completed yet

  // Output registers
  logic       r_msg_valid;
  logic [7:0] r_msg_status;
  logic [6:0] r_msg_data1;
  logic [6:0] r_msg_data2;
  logic       r_rt_valid;
  logic [7:0] r_rt_byte;
  logic       r_err;

  // Combinational decisions for this cycle
  logic       w_accept;
  logic       w_emit;
  logic [7:0] w_emit_status;
  logic [6:0] w_emit_d1;
  logic [6:0] w_emit_d2;
  logic       w_err;
  logic       w_rt;
  logic [1:0] w_run_len;
  logic       w_run_is_sys;
  logic       w_pass;
  logic [7:0] w_out_status;

  assign w_accept     = byte_strobe && !r_strobe_q;
  assign w_run_len    = status_data_len(r_status);
  assign w_run_is_sys = (r_status[7:4] == 4'hF);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_data1_nxt   = r_data1;
    w_partial_nxt = r_partial;
    w_emit        = 1'b0;
    w_emit_status = r_status;
    w_emit_d1     = '0;
    w_emit_d2     = '0;
    w_err         = 1'b0;
    w_rt          = 1'b0;

    if (w_accept) begin
      if (byte_is_cmd && w_is_realtime) begin
        // Real-time bytes never disturb the message in progress.
        w_rt = 1'b1;
      end else if (byte_is_cmd) begin
        // Any other status abandons an unfinished message, then is processed
        // from a clean slate in this same cycle.
        w_err         = r_partial || (r_state == WAIT_D2);
        w_partial_nxt = 1'b0;
        w_status_nxt  = '0;
        w_state_nxt   = IDLE;
        if (w_is_channel) begin
          w_status_nxt  = w_byte;
          w_state_nxt   = WAIT_D1;
          w_partial_nxt = 1'b1;
        end else if (w_byte == SYSEX_START) begin
          w_state_nxt = SYSEX;
        end else if (w_byte == SYSEX_END) begin
          if (r_state != SYSEX) w_err = 1'b1;
        end else if (w_byte == TUNE_REQ) begin
          w_emit        = 1'b1;
          w_emit_status = TUNE_REQ;
        end else if (w_is_sys_common && (w_len != 2'd0)) begin
          w_status_nxt  = w_byte;
          w_state_nxt   = WAIT_D1;
          w_partial_nxt = 1'b1;
        end
        // F4/F5 fall through: running status cleared, back to IDLE.
      end else begin
        case (r_state)
          IDLE: w_err = 1'b1;
          WAIT_D1: begin
            if (w_run_len == 2'd1) begin
              w_emit        = 1'b1;
              w_emit_d1     = w_byte[6:0];
              w_partial_nxt = 1'b0;
              if (w_run_is_sys) begin
                w_status_nxt = '0;
                w_state_nxt  = IDLE;
              end
            end else begin
              w_data1_nxt = w_byte[6:0];
              w_state_nxt = WAIT_D2;
            end
          end
          WAIT_D2: begin
            w_emit        = 1'b1;
            w_emit_d1     = r_data1;
            w_emit_d2     = w_byte[6:0];
            w_partial_nxt = 1'b0;
            if (w_run_is_sys) begin
              w_status_nxt = '0;
              w_state_nxt  = IDLE;
            end else begin
              w_state_nxt = WAIT_D1;
            end
          end
          default: ;  // SYSEX payload is discarded silently
        endcase
      end
    end
  end

  // Channel filter and velocity-0 Note On rewrite on the emitted message.
  always_comb begin
    w_pass       = OMNI || (w_emit_status[7:4] == 4'hF) || (w_emit_status[3:0] == CHANNEL);
    w_out_status = w_emit_status;
    if (NOTEON_V0_TO_OFF && (w_emit_status[7:4] == NOTE_ON[7:4]) && (w_emit_d2 == 7'd0)) begin
      w_out_status = {NOTE_OFF[7:4], w_emit_status[3:0]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // Starting high means a strobe already asserted at reset release is
      // not mistaken for a rising edge.
      r_strobe_q   <= 1'b1;
      r_state      <= IDLE;
      r_status     <= '0;
      r_data1      <= '0;
      r_partial    <= 1'b0;
      r_msg_valid  <= 1'b0;
      r_msg_status <= '0;
      r_msg_data1  <= '0;
      r_msg_data2  <= '0;
      r_rt_valid   <= 1'b0;
      r_rt_byte    <= '0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_strobe_q  <= byte_strobe;
      r_state     <= w_state_nxt;
      r_status    <= w_status_nxt;
      r_data1     <= w_data1_nxt;
      r_partial   <= w_partial_nxt;
      r_msg_valid <= w_emit && w_pass;
      r_rt_valid  <= w_rt;
      r_err       <= w_err;
      if (w_emit && w_pass) begin
        r_msg_status <= w_out_status;
        r_msg_data1  <= w_emit_d1;
        r_msg_data2  <= w_emit_d2;
      end
      if (w_rt) r_rt_byte <= w_byte;
    end
  end

  assign msg_valid    = r_msg_valid;
  assign msg_status   = r_msg_status;
  assign msg_data1    = r_msg_data1;
  assign msg_data2    = r_msg_data2;
  assign rt_valid     = r_rt_valid;
  assign rt_byte      = r_rt_byte;
  assign err_strobe   = r_err;
  assign sysex_active = (r_state == SYSEX);

endmodule
